addr_sequencer: RTL and testbench
=================================

Name: addr_sequencer

Overview:
- Address and sequencing datapath directly downstream of the control FSM.
- Consumes the FSM's one-per-cycle `STATE_*` code and owns the program counter (PC), stack pointer (SP), memory address register (MAR) and CALL target latch.
- Drives the memory address, write-enable and write-data mux.
- Updates PC/SP for fetch, jump, push/pop, call and return sequences.

Parameters:
- WIDTH, 8, width of address/data path, PC, SP, MAR.
- PC_INIT, 8'h00, PC value after reset.
- SP_INIT, 8'hFF, SP value after reset; SP points to next free slot.

Ports:
- clk  in  1  system clock; all updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- state  in  8  current FSM state code (`STATE_*`).
- opcode  in  8  current instruction opcode (`OP_*`).
- mem_rdata  in  WIDTH  memory read data at mem_addr.
- reg_data  in  WIDTH  selected register-file output, for PUSH/STX.
- mem_addr  out  WIDTH  registered MAR.
- mem_we  out  1  memory write strobe, combinational from state.
- mem_wdata  out  WIDTH  memory write data, combinational mux.
- pc  out  WIDTH  registered program counter.
- sp  out  WIDTH  registered stack pointer.
- halted  out  1  sticky halt flag.
- stack_fault  out  1  sticky stack over/underflow flag.

Behaviour:
- Reset (async, any time, including mid-CALL): pc=PC_INIT, sp=SP_INIT, MAR=0, tmp=0, halted=0, stack_fault=0. Outputs hold these until the first posedge after reset deasserts.
- Only one state is presented per cycle. Actions happen at the posedge on which state holds the code, so there are no simultaneous PC/SP conflicts.
- Per-state actions at the posedge:
  - FETCH_PC: MAR<=pc; pc<=pc+1.
  - FETCH_SP: MAR<=sp.
  - INC_SP: sp<=sp+1; if sp==8'hFF, set stack_fault (pop from empty).
  - STACK_REG: mem write of reg_data at MAR; sp<=sp-1; if sp==0, set stack_fault.
  - STORE_PC: mem write of pc at MAR; sp<=sp-1; if sp==0, set stack_fault.
  - SET_MEM: mem write of reg_data at MAR; no pointer change.
  - LOAD_ADDR: MAR<=mem_rdata.
  - JUMP: pc<=mem_rdata.
  - SET_REG with opcode==OP_CALL: tmp<=mem_rdata. With any other opcode: no action (register file handles it).
  - TMP_JUMP: pc<=tmp.
  - RET: pc<=mem_rdata.
  - HALT: halted<=1.
  - NEXT, FETCH_INST, MOV_REG, ALU_EXEC, ALU_OUT: no action here.
- mem_we=1 exactly when state is STACK_REG, STORE_PC or SET_MEM.
- mem_wdata = pc in STORE_PC, otherwise reg_data.
- Arithmetic is modulo 2^WIDTH: pc wraps FF->00; sp wraps both ways. stack_fault is informational; wrap still occurs.
- Once halted=1: all registers frozen and mem_we forced 0 regardless of state, until reset.
- Unknown or X state codes (the FSM default case): no register update, mem_we=0.
- Stack convention: push writes at sp then decrements; pop increments then reads. CALL pushes the return PC, which already points past the target byte.

Decomposition:
- `STATE_*` and `OP_*` codes come from the shared symbols header; no literal codes in this block.
- Add to the header: SP_INIT/PC_INIT defaults.
- One natural sub-module: addr_wdata_mux, combinational mem_we/mem_wdata decode. Keep it inline if under ~30 lines.
- Remainder is a single always block plus the halted/fault flags.

Test Plan:
- Reset, then FETCH_PC x3 -> mem_addr=00,01,02; pc=03; sp=FF; halted=0.
- pc=FF, FETCH_PC -> mem_addr=FF, pc=00, no fault.
- PUSH with reg_data=5A, sp=FF: FETCH_SP, STACK_REG -> mem_we=1 at addr FF, wdata=5A, then sp=FE. POP: INC_SP, FETCH_SP -> sp=FF, mem_addr=FF.
- CALL at pc=10, mem_rdata=40, sp=FF: FETCH_PC, SET_REG(OP_CALL), FETCH_SP, STORE_PC, TMP_JUMP -> write 11 at FF, sp=FE, pc=40. Then RET with mem_rdata=11: INC_SP, FETCH_SP, RET -> sp=FF, pc=11.
- sp=00, STACK_REG -> sp=FF, stack_fault=1 and stays 1. sp=FF, INC_SP from fresh reset -> stack_fault=1.
- HALT, then FETCH_PC/STACK_REG -> pc/sp unchanged, mem_we=0. Assert reset mid-cycle -> pc=00, halted=0 immediately.

Source files
------------

// File: rtl/addr_sequencer_pkg.sv
// Shared state/opcode symbols and reset defaults for the address sequencer.
// The FSM-side code values live here so no literal codes appear in the datapath.
package addr_sequencer_pkg;

    localparam logic [7:0] STATE_FETCH_PC   = 8'h01;
    localparam logic [7:0] STATE_FETCH_INST = 8'h02;
    localparam logic [7:0] STATE_NEXT       = 8'h03;
    localparam logic [7:0] STATE_FETCH_SP   = 8'h04;
    localparam logic [7:0] STATE_INC_SP     = 8'h05;
    localparam logic [7:0] STATE_STACK_REG  = 8'h06;
    localparam logic [7:0] STATE_STORE_PC   = 8'h07;
    localparam logic [7:0] STATE_SET_MEM    = 8'h08;
    localparam logic [7:0] STATE_LOAD_ADDR  = 8'h09;
    localparam logic [7:0] STATE_JUMP       = 8'h0A;
    localparam logic [7:0] STATE_SET_REG    = 8'h0B;
    localparam logic [7:0] STATE_TMP_JUMP   = 8'h0C;
    localparam logic [7:0] STATE_RET        = 8'h0D;
    localparam logic [7:0] STATE_HALT       = 8'h0E;
    localparam logic [7:0] STATE_MOV_REG    = 8'h0F;
    localparam logic [7:0] STATE_ALU_EXEC   = 8'h10;
    localparam logic [7:0] STATE_ALU_OUT    = 8'h11;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_MOV  = 8'h10;
    localparam logic [7:0] OP_JMP  = 8'h20;
    localparam logic [7:0] OP_CALL = 8'h30;
    localparam logic [7:0] OP_RET  = 8'h31;
    localparam logic [7:0] OP_PUSH = 8'h40;
    localparam logic [7:0] OP_POP  = 8'h41;
    localparam logic [7:0] OP_HLT  = 8'hFF;

    localparam logic [7:0] DEF_PC_INIT = 8'h00;
    localparam logic [7:0] DEF_SP_INIT = 8'hFF;

    // States that drive a memory write cycle.
    function automatic logic is_write_state(input logic [7:0] st);
        return (st == STATE_STACK_REG) || (st == STATE_STORE_PC) || (st == STATE_SET_MEM);
    endfunction

endpackage

// File: rtl/addr_sequencer_wdata_mux.sv
// Combinational memory write strobe and write-data select.
// A halted machine never writes, whatever state code the FSM presents.
module addr_sequencer_wdata_mux
    import addr_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [7:0]       state,
    input  logic             halted,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] reg_data,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata
);

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = reg_data;
        if (!halted && is_write_state(state)) begin
            mem_we = 1'b1;
        end
        if (state == STATE_STORE_PC) begin
            mem_wdata = pc;
        end
    end

endmodule

// File: rtl/addr_sequencer.sv
// PC / SP / MAR / CALL-target datapath driven by the control FSM's state code.
// All pointer arithmetic wraps modulo 2^WIDTH; stack_fault only records the wrap.
module addr_sequencer
    import addr_sequencer_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] PC_INIT = WIDTH'(DEF_PC_INIT),
    parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(DEF_SP_INIT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       state,
    input  logic [7:0]       opcode,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [WIDTH-1:0] reg_data,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] sp,
    output logic             halted,
    output logic             stack_fault
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] tmp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= PC_INIT;
            sp          <= SP_INIT;
            mem_addr    <= '0;
            tmp         <= '0;
            halted      <= 1'b0;
            stack_fault <= 1'b0;
        end else if (!halted) begin
            case (state)
                STATE_FETCH_PC: begin
                    mem_addr <= pc;
                    pc       <= pc + ONE;
                end
                STATE_FETCH_SP: mem_addr <= sp;
                STATE_INC_SP: begin
                    sp <= sp + ONE;
                    if (sp == '1) stack_fault <= 1'b1;
                end
                STATE_STACK_REG, STATE_STORE_PC: begin
                    // push: the write at MAR happens this cycle, then sp moves down
                    sp <= sp - ONE;
                    if (sp == '0) stack_fault <= 1'b1;
                end
                STATE_LOAD_ADDR: mem_addr <= mem_rdata;
                STATE_JUMP:      pc <= mem_rdata;
                STATE_SET_REG: begin
                    if (opcode == OP_CALL) tmp <= mem_rdata;
                end
                STATE_TMP_JUMP:  pc <= tmp;
                STATE_RET:       pc <= mem_rdata;
                STATE_HALT:      halted <= 1'b1;
                default: ;
            endcase
        end
    end

    addr_sequencer_wdata_mux #(
        .WIDTH (WIDTH)
    ) u_wdata_mux (
        .state     (state),
        .halted    (halted),
        .pc        (pc),
        .reg_data  (reg_data),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed test-plan sequence followed by random state streams, checked against
// a behavioural model of the pointer registers.
module tb_addr_sequencer;
    import addr_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] state = STATE_NEXT;
    logic [7:0] opcode = OP_NOP;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] reg_data = 8'h00;
    logic [7:0] mem_addr, mem_wdata, pc, sp;
    logic       mem_we, halted, stack_fault;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_pc, m_sp, m_mar, m_tmp;
    logic       m_halt, m_fault;

    logic [7:0] valid_states [17] = '{
        STATE_FETCH_PC, STATE_FETCH_INST, STATE_NEXT, STATE_FETCH_SP, STATE_INC_SP,
        STATE_STACK_REG, STATE_STORE_PC, STATE_SET_MEM, STATE_LOAD_ADDR, STATE_JUMP,
        STATE_SET_REG, STATE_TMP_JUMP, STATE_RET, STATE_HALT, STATE_MOV_REG,
        STATE_ALU_EXEC, STATE_ALU_OUT};

    addr_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .opcode      (opcode),
        .mem_rdata   (mem_rdata),
        .reg_data    (reg_data),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .pc          (pc),
        .sp          (sp),
        .halted      (halted),
        .stack_fault (stack_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_sp = 8'hFF; m_mar = 8'h00; m_tmp = 8'h00;
        m_halt = 1'b0; m_fault = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".sp"}, sp, m_sp);
        chk({tag, ".mem_addr"}, mem_addr, m_mar);
        chk({tag, ".halted"}, {7'd0, halted}, {7'd0, m_halt});
        chk({tag, ".stack_fault"}, {7'd0, stack_fault}, {7'd0, m_fault});
    endtask

    // One FSM cycle: present inputs, check the combinational write path,
    // then advance the model alongside the DUT's posedge.
    task automatic step(input string tag, input logic [7:0] st, input logic [7:0] op,
                        input logic [7:0] rd, input logic [7:0] rg);
        logic       exp_we;
        logic [7:0] exp_wd;
        state = st; opcode = op; mem_rdata = rd; reg_data = rg;
        #1;
        exp_we = 1'b0;
        exp_wd = rg;
        case (st)
            STATE_STACK_REG, STATE_SET_MEM: exp_we = !m_halt;
            STATE_STORE_PC: begin exp_we = !m_halt; exp_wd = m_pc; end
            default: ;
        endcase
        chk({tag, ".mem_we"}, {7'd0, mem_we}, {7'd0, exp_we});
        chk({tag, ".mem_wdata"}, mem_wdata, exp_wd);
        if (!m_halt) begin
            case (st)
                STATE_FETCH_PC:  begin m_mar = m_pc; m_pc = m_pc + 8'd1; end
                STATE_FETCH_SP:  m_mar = m_sp;
                STATE_INC_SP:    begin if (m_sp == 8'hFF) m_fault = 1'b1; m_sp = m_sp + 8'd1; end
                STATE_STACK_REG,
                STATE_STORE_PC:  begin if (m_sp == 8'h00) m_fault = 1'b1; m_sp = m_sp - 8'd1; end
                STATE_LOAD_ADDR: m_mar = rd;
                STATE_JUMP,
                STATE_RET:       m_pc = rd;
                STATE_SET_REG:   if (op == OP_CALL) m_tmp = rd;
                STATE_TMP_JUMP:  m_pc = m_tmp;
                STATE_HALT:      m_halt = 1'b1;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        model_reset();
        #1;
        check_regs(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] st, op;
        @(posedge clk);
        #1;
        do_reset("reset");

        step("fetch0", STATE_FETCH_PC, OP_NOP, 8'h00, 8'h00);
        step("fetch1", STATE_FETCH_PC, OP_NOP, 8'h00, 8'h00);
        step("fetch2", STATE_FETCH_PC, OP_NOP, 8'h00, 8'h00);
        chk("plan.fetch_pc", pc, 8'h03);
        chk("plan.fetch_addr", mem_addr, 8'h02);

        step("jmp_ff", STATE_JUMP, OP_JMP, 8'hFF, 8'h00);
        step("pc_wrap", STATE_FETCH_PC, OP_NOP, 8'h00, 8'h00);
        chk("plan.pc_wrap", pc, 8'h00);
        chk("plan.wrap_addr", mem_addr, 8'hFF);

        step("push_sp", STATE_FETCH_SP, OP_PUSH, 8'h00, 8'h5A);
        state = STATE_STACK_REG; reg_data = 8'h5A;
        #1;
        chk("plan.push_we", {7'd0, mem_we}, 8'h01);
        chk("plan.push_wdata", mem_wdata, 8'h5A);
        step("push_wr", STATE_STACK_REG, OP_PUSH, 8'h00, 8'h5A);
        chk("plan.push_sp", sp, 8'hFE);
        step("pop_inc", STATE_INC_SP, OP_POP, 8'h00, 8'h00);
        step("pop_sp", STATE_FETCH_SP, OP_POP, 8'h5A, 8'h00);
        chk("plan.pop_sp", sp, 8'hFF);

        step("call_jmp", STATE_JUMP, OP_JMP, 8'h10, 8'h00);
        step("call_fetch", STATE_FETCH_PC, OP_CALL, 8'h00, 8'h00);
        step("call_tmp", STATE_SET_REG, OP_CALL, 8'h40, 8'h00);
        step("call_sp", STATE_FETCH_SP, OP_CALL, 8'h00, 8'h00);
        step("call_store", STATE_STORE_PC, OP_CALL, 8'h00, 8'h77);
        step("call_jump", STATE_TMP_JUMP, OP_CALL, 8'h00, 8'h00);
        chk("plan.call_pc", pc, 8'h40);
        chk("plan.call_sp", sp, 8'hFE);
        step("ret_inc", STATE_INC_SP, OP_RET, 8'h00, 8'h00);
        step("ret_sp", STATE_FETCH_SP, OP_RET, 8'h11, 8'h00);
        step("ret_pc", STATE_RET, OP_RET, 8'h11, 8'h00);
        chk("plan.ret_pc", pc, 8'h11);
        chk("plan.ret_sp", sp, 8'hFF);

        step("setreg_nocall", STATE_SET_REG, OP_MOV, 8'h99, 8'h00);
        step("tmpjmp_kept", STATE_TMP_JUMP, OP_MOV, 8'h00, 8'h00);
        step("x_state", 8'hxx, OP_NOP, 8'h33, 8'h44);
        step("unknown", 8'hC3, OP_NOP, 8'h33, 8'h44);

        do_reset("reset2");
        step("underflow", STATE_INC_SP, OP_POP, 8'h00, 8'h00);
        chk("plan.underflow", {7'd0, stack_fault}, 8'h01);

        do_reset("reset3");
        for (int i = 0; i < 255; i++) step("fill", STATE_STACK_REG, OP_PUSH, 8'h00, 8'(i));
        chk("plan.sp_zero", sp, 8'h00);
        chk("plan.no_fault", {7'd0, stack_fault}, 8'h00);
        step("overflow", STATE_STACK_REG, OP_PUSH, 8'h00, 8'hA5);
        chk("plan.overflow_sp", sp, 8'hFF);
        step("sticky", STATE_INC_SP, OP_POP, 8'h00, 8'h00);
        chk("plan.sticky", {7'd0, stack_fault}, 8'h01);

        step("halt", STATE_HALT, OP_HLT, 8'h00, 8'h00);
        step("halt_fetch", STATE_FETCH_PC, OP_NOP, 8'h00, 8'h00);
        step("halt_push", STATE_STACK_REG, OP_PUSH, 8'h00, 8'h12);
        chk("plan.halt_pc", pc, 8'h00);
        state = STATE_STACK_REG;
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("plan.midreset_pc", pc, 8'h00);
        chk("plan.midreset_halted", {7'd0, halted}, 8'h00);
        check_regs("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset("rnd_reset");
            end else begin
                st = valid_states[$urandom_range(16)];
                if (st == STATE_HALT && $urandom_range(9) != 0) st = STATE_NEXT;
                if ($urandom_range(19) == 0) st = 8'($urandom_range(255, 18));
                op = ($urandom_range(1) == 0) ? OP_CALL : 8'($urandom);
                step("rnd", st, op, 8'($urandom), 8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
